// File: rtl/cacheline_adapter_pkg.sv
// Shared types for the icache-to-banked-memory cacheline adapter.
package cacheline_adapter_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } adapter_state_t;

    localparam int BEATS = 4;

    // Lines are 32 bytes, so the low five address bits never reach memory.
    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Bundle of the icache-facing (ufp) and memory-facing (bmem) signals of the adapter.
interface cacheline_adapter_if #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
);
    logic [31:0]          ufp_addr;
    logic                 ufp_read;
    logic                 ufp_write;
    logic [LINE_BITS-1:0] ufp_wdata;
    logic                 ufp_ready;
    logic [31:0]          ufp_raddr;
    logic [LINE_BITS-1:0] ufp_rdata;
    logic                 ufp_rvalid;

    logic [31:0]          bmem_addr;
    logic                 bmem_read;
    logic                 bmem_write;
    logic [BEAT_BITS-1:0] bmem_wdata;
    logic                 bmem_ready;
    logic [31:0]          bmem_raddr;
    logic [BEAT_BITS-1:0] bmem_rdata;
    logic                 bmem_rvalid;

    // The adapter's view: it serves the icache and drives the memory.
    modport slave (
        input  ufp_addr, ufp_read, ufp_write, ufp_wdata,
        output ufp_ready, ufp_raddr, ufp_rdata, ufp_rvalid,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    // The environment's view: icache requests plus the memory's responses.
    modport master (
        output ufp_addr, ufp_read, ufp_write, ufp_wdata,
        input  ufp_ready, ufp_raddr, ufp_rdata, ufp_rvalid,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits cacheline writes into 4 memory beats and reassembles 4 read beats into a line.
// One transaction in flight; the line buffer serves both directions.
module cacheline_adapter
    import cacheline_adapter_types::*;
#(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = LINE_BITS / BEATS
) (
    input logic                clk,
    input logic                rst,
    cacheline_adapter_if.slave bus
);

    localparam int NB = LINE_BITS / BEAT_BITS;
    localparam int CW = $clog2(NB);

    adapter_state_t       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          raddr_q, raddr_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 last_beat;

    assign last_beat      = (cnt_q == CW'(NB - 1));
    assign bus.ufp_raddr  = raddr_q;
    assign bus.ufp_rdata  = rdata_q;
    assign bus.ufp_rvalid = rvalid_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        line_d         = line_q;
        raddr_d        = raddr_q;
        rdata_d        = rdata_q;
        rvalid_d       = 1'b0;
        bus.ufp_ready  = 1'b0;
        bus.bmem_addr  = addr_q;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_wdata = line_q[cnt_q*BEAT_BITS +: BEAT_BITS];
        unique case (state_q)
            IDLE: begin
                // Commands leave in the accept cycle, straight from the request.
                bus.ufp_ready  = bus.bmem_ready;
                bus.bmem_addr  = line_align(bus.ufp_addr);
                bus.bmem_wdata = bus.ufp_wdata[BEAT_BITS-1:0];
                if (bus.bmem_ready && bus.ufp_write) begin
                    bus.bmem_write = 1'b1;
                    addr_d         = line_align(bus.ufp_addr);
                    line_d         = bus.ufp_wdata;
                    cnt_d          = CW'(1);
                    state_d        = WRITE;
                end else if (bus.bmem_ready && bus.ufp_read) begin
                    bus.bmem_read = 1'b1;
                    addr_d        = line_align(bus.ufp_addr);
                    cnt_d         = '0;
                    state_d       = READ;
                end
            end
            WRITE: begin
                bus.bmem_write = 1'b1;
                if (bus.bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = IDLE;
                end
            end
            READ: begin
                if (bus.bmem_rvalid) begin
                    line_d[cnt_q*BEAT_BITS +: BEAT_BITS] = bus.bmem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b1;
                        raddr_d  = addr_q;
                        rdata_d  = line_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            line_q   <= '0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.ufp_read && bus.ufp_write));

    a_burst_addr: assert property (@(posedge clk) disable iff (rst)
        (bus.bmem_rvalid && state_q == READ) |-> bus.bmem_raddr == addr_q);

    // Stale beats after a reset are legal to receive; they are only reported.
    a_stray_beat: assert property (@(posedge clk) disable iff (rst)
        bus.bmem_rvalid |-> state_q == READ)
        else $warning("bmem_rvalid outside READ dropped");

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: directed requests, a latency-3 memory responder,
// and independent monitors for returned lines, write beats and read commands.
module tb_cacheline_adapter;
    import cacheline_adapter_types::*;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] line;
        bit           abort;
    } rd_job_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cacheline_adapter_if #(.LINE_BITS(256), .BEAT_BITS(64)) bus ();
    cacheline_adapter #(.LINE_BITS(256), .BEAT_BITS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    rd_job_t  mem_q[$];
    rd_job_t  exp_q[$];
    wr_beat_t wexp_q[$];
    int       acc_q[$];
    rd_job_t  mon_e;
    bit       resp_busy = 0;
    bit       half_done = 0;
    bit       rst_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    task automatic exp_read(input logic [31:0] aligned, input logic [255:0] line);
        rd_job_t j;
        j.addr = aligned; j.line = line; j.abort = 0;
        mem_q.push_back(j);
        exp_q.push_back(j);
    endtask

    task automatic exp_write(input logic [31:0] aligned, input logic [255:0] line);
        wr_beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.addr = aligned; b.data = line[k*64 +: 64];
            wexp_q.push_back(b);
        end
    endtask

    // Called just after a posedge; returns just after the posedge that took the request.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [255:0] wdata,
                         output int acc, output bit with_rv);
        bus.ufp_addr = addr; bus.ufp_wdata = wdata;
        bus.ufp_write = wr; bus.ufp_read = !wr;
        acc = -1; with_rv = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.ufp_ready) begin acc = cyc; with_rv = bus.ufp_rvalid; break; end
        end
        if (acc < 0) fail("accept_timeout");
        @(posedge clk); #1;
        bus.ufp_read = 0; bus.ufp_write = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0 || wexp_q.size() != 0 || resp_busy) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) fail(name);
        @(posedge clk); #1;
    endtask

    task automatic write_len(input string name, input int acc, input int want);
        int t = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.ufp_ready) begin t = cyc; break; end
        end
        chk(name, 256'(t - acc), 256'(want));
    endtask

    // Memory model: answers each bmem_read with 4 in-order beats after LAT cycles.
    initial begin : responder
        rd_job_t j;
        bus.bmem_rvalid = 0; bus.bmem_rdata = '0; bus.bmem_raddr = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.bmem_read) begin
                if (mem_q.size() == 0) fail("bmem_read_unexpected");
                else begin
                    j = mem_q.pop_front();
                    chk("bmem_raddr_cmd", 256'(bus.bmem_addr), 256'(j.addr));
                    if (!j.abort) acc_q.push_back(cyc);
                    resp_busy = 1;
                    repeat (LAT) @(posedge clk);
                    #1;
                    for (int k = 0; k < 4; k++) begin
                        if (j.abort && k == 2) begin
                            bus.bmem_rvalid = 0; half_done = 1;
                            for (int n = 0; n < 50 && !rst_done; n++) begin @(posedge clk); #1; end
                            if (!rst_done) fail("reset_handshake_timeout");
                        end
                        bus.bmem_rvalid = 1; bus.bmem_raddr = j.addr; bus.bmem_rdata = j.line[k*64 +: 64];
                        @(posedge clk); #1;
                    end
                    bus.bmem_rvalid = 0; half_done = 0; resp_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.ufp_rvalid) begin
            if (exp_q.size() == 0) fail("ufp_rvalid_unexpected");
            else begin
                mon_e = exp_q.pop_front();
                chk("ufp_raddr", 256'(bus.ufp_raddr), 256'(mon_e.addr));
                chk("ufp_rdata", bus.ufp_rdata, mon_e.line);
                if (acc_q.size() != 0) chk("rvalid_latency", 256'(cyc - acc_q.pop_front()), 256'(LAT + 4));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.bmem_write) begin
            if (wexp_q.size() == 0) fail("bmem_write_unexpected");
            else begin
                chk("bmem_wdata", 256'(bus.bmem_wdata), 256'(wexp_q[0].data));
                chk("bmem_waddr", 256'(bus.bmem_addr), 256'(wexp_q[0].addr));
                if (bus.bmem_ready) wexp_q.delete(0);
            end
        end
    end

    initial begin : main
        int acc, acc2, t0;
        bit rv, rv2;
        rd_job_t ab;
        logic [255:0] l1, lw, lw2, lx, ly, lz, lab;
        l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lw  = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002, 64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
        lw2 = {64'h0F0F_0F0F_0000_0004, 64'h0E0E_0E0E_0000_0003, 64'h0D0D_0D0D_0000_0002, 64'h0C0C_0C0C_0000_0001};
        lx  = {64'hA5A5_0000_0000_0004, 64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0001};
        ly  = {64'h5A5A_1111_2222_3333, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_CAFE_F00D};
        lz  = {64'h7777_0000_0000_0007, 64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005, 64'h9999_0000_0000_0009};
        lab = {64'hBAD0_0000_0000_0004, 64'hBAD0_0000_0000_0003, 64'hBAD0_0000_0000_0002, 64'hBAD0_0000_0000_0001};
        bus.ufp_addr = '0; bus.ufp_read = 0; bus.ufp_write = 0; bus.ufp_wdata = '0; bus.bmem_ready = 1;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_rvalid", 256'(bus.ufp_rvalid), 256'(0));
        chk("rst_rdata", bus.ufp_rdata, 256'(0));
        chk("rst_raddr", 256'(bus.ufp_raddr), 256'(0));
        chk("rst_bmem_read", 256'(bus.bmem_read), 256'(0));
        chk("rst_bmem_write", 256'(bus.bmem_write), 256'(0));
        chk("rst_ufp_ready", 256'(bus.ufp_ready), 256'(1));
        @(posedge clk); #1;

        // Single read, L=3
        exp_read(32'h0000_1040, l1);
        issue(0, 32'h0000_1040, '0, acc, rv);
        drain("read1_drain");

        // Write with memory stalling the second beat: A,B,B,C,D
        exp_write(32'h0000_2000, lw);
        issue(1, 32'h0000_2000, lw, acc, rv);
        bus.bmem_ready = 0;
        @(posedge clk); #1;
        bus.bmem_ready = 1;
        write_len("write_stall_len", acc, 5);
        @(posedge clk); #1;

        exp_write(32'h0000_3000, lw2);
        issue(1, 32'h0000_3000, lw2, acc, rv);
        write_len("write_len", acc, 4);
        drain("write_drain");

        // Back-to-back reads: second accepted in the first's rvalid cycle
        exp_read(32'h0000_4000, lx);
        exp_read(32'h0000_5020, ly);
        issue(0, 32'h0000_4000, '0, acc, rv);
        issue(0, 32'h0000_5020, '0, acc2, rv2);
        chk("b2b_accept_with_rvalid", 256'(rv2), 256'(1));
        chk("b2b_accept_gap", 256'(acc2 - acc), 256'(LAT + 4));
        drain("b2b_drain");

        // Memory not ready: request waits
        exp_read(32'h0000_6000, lz);
        bus.bmem_ready = 0; bus.ufp_addr = 32'h0000_6000; bus.ufp_read = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ufp_ready", 256'(bus.ufp_ready), 256'(0));
            chk("stall_bmem_read", 256'(bus.bmem_read), 256'(0));
        end
        @(posedge clk); #1;
        bus.bmem_ready = 1; t0 = cyc;
        issue(0, 32'h0000_6000, '0, acc, rv);
        chk("stall_accept_first", 256'(acc - t0), 256'(0));
        drain("stall_drain");

        // Reset after two beats; the two remaining beats arrive as strays
        ab.addr = 32'h0000_7000; ab.line = lab; ab.abort = 1;
        mem_q.push_back(ab);
        issue(0, 32'h0000_7000, '0, acc, rv);
        t0 = 0;
        for (int n = 0; n < 100 && !half_done; n++) begin @(negedge clk); t0 = n; end
        if (!half_done) fail("half_burst_timeout");
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0; rst_done = 1;
        for (int n = 0; n < 100 && resp_busy; n++) @(negedge clk);
        if (resp_busy) fail("stray_beats_timeout");
        rst_done = 0;
        @(negedge clk);
        chk("abort_rdata", bus.ufp_rdata, 256'(0));
        chk("abort_raddr", 256'(bus.ufp_raddr), 256'(0));
        chk("abort_state", 256'(dut.state_q), 256'(IDLE));
        chk("abort_ufp_ready", 256'(bus.ufp_ready), 256'(1));
        @(posedge clk); #1;

        // Unaligned request after reset: aligned downstream
        exp_read(32'h0000_1040, l1 ^ lz);
        issue(0, 32'h0000_105C, '0, acc, rv);
        drain("unaligned_drain");

        chk("queues_empty", 256'(exp_q.size() + mem_q.size() + wexp_q.size() + acc_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Converts 256-bit cacheline requests from the icache's downward-facing port into 4-beat, 64-bit bursts on the banked memory interface, and reassembles read bursts into a full line. Sits directly downstream of the icache `dfp` port and upstream of the memory model/arbiter. Only one transaction is in flight at a time.

## Interface

**Parameters**
- `LINE_BITS`, default 256: cacheline width.
- `BEAT_BITS`, default 64: memory beat width. `BEATS = LINE_BITS/BEAT_BITS` (4).

**Ports**
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `ufp_addr` in 32: line address. Bits [4:0] are ignored and forced to 0 downstream.
- `ufp_read` in 1: line read request.
- `ufp_write` in 1: line write request.
- `ufp_wdata` in 256: write line.
- `ufp_ready` out 1: request accepted this cycle if read or write is high.
- `ufp_raddr` out 32: address of the returned line.
- `ufp_rdata` out 256: returned line; beat k is at bits [64k+63:64k].
- `ufp_rvalid` out 1: one-cycle pulse, line valid.
- `bmem_addr` out 32: burst address, 32-byte aligned.
- `bmem_read` out 1: one-cycle read command.
- `bmem_write` out 1: write beat valid.
- `bmem_wdata` out 64: write beat.
- `bmem_ready` in 1: memory can take a command/beat this cycle.
- `bmem_raddr` in 32: address of the returning burst.
- `bmem_rdata` in 64: read beat.
- `bmem_rvalid` in 1: read beat valid.

## Operation

**States**
- `IDLE`, `WRITE`, `READ`.

**IDLE**
- `ufp_ready = bmem_ready`.
- Accepted read: `bmem_read=1` and `bmem_addr={ufp_addr[31:5],5'b0}` combinationally in the same cycle. Address is latched, beat count cleared, go to `READ`.
- Accepted write: `bmem_write=1` with `bmem_wdata=ufp_wdata[63:0]` in the same cycle. Line and address are latched, beat count set to 1, go to `WRITE`.
- Read and write both high is illegal (assertion). Write wins.

**WRITE**
- `bmem_write=1`, `bmem_addr` = latched address, `bmem_wdata` = latched beat[count].
- Count advances only when `bmem_ready=1`. When `bmem_ready=0` the same beat is held.
- After beat 3 is taken, go to `IDLE`.
- No completion response is sent upstream for writes.

**READ**
- On each `bmem_rvalid`, store `bmem_rdata` into beat[count] and increment count.
- On the 4th beat, go to `IDLE` and register `ufp_rvalid=1` for the following cycle, with `ufp_raddr` = latched address.
- Beats are always in order, beat 0 first.
- Assertion: `bmem_raddr` equals the latched address whenever `bmem_rvalid` is high.

**Other rules**
- `ufp_ready=0` in `WRITE` and `READ`.
- `bmem_rvalid` while in `IDLE`/`WRITE` is ignored (assertion flags it).
- `ufp_rdata`/`ufp_raddr` hold their last value until the next line completes.

## Timing

**Reset**
- `rst` returns the FSM to `IDLE` and clears the count, `ufp_rvalid`, `bmem_read` and `bmem_write`.
- `ufp_rdata`, `ufp_raddr` and the latched line reset to 0.
- Reset mid-burst drops the partial line. Stale beats arriving after reset are ignored.

**Latency**
- Read: accept cycle T. Beats arrive T+L..T+L+3 (L is memory latency). `ufp_rvalid` is asserted at T+L+4.
- The FSM is back in `IDLE` during the `ufp_rvalid` cycle, so a new request can be accepted that same cycle.
- Write: minimum 4 cycles (T..T+3). Each `bmem_ready=0` cycle adds one.

**Widths**
- The beat counter is 2 bits and wraps to 0 on completion.

## Structure

- Package `cacheline_adapter_types`: state enum `adapter_state_t {IDLE, WRITE, READ}` and localparam `BEATS`.
- Single module. Beat counter and line buffer are inline; no sub-module is warranted.
- The line buffer is shared between write data and read assembly, since only one transaction is in flight.

## Test plan

- Read 0x0000_1040, `bmem_ready=1`, L=3, beats 0x11..,0x22..,0x33..,0x44.. → one `bmem_read` with addr 0x0000_1040. `ufp_rvalid` 7 cycles after accept, `ufp_rdata={0x44..,0x33..,0x22..,0x11..}`, `ufp_raddr=0x0000_1040`.
- Write to 0x0000_2000 with line beats A,B,C,D and `bmem_ready` low in the 2nd cycle → `bmem_wdata` sequence A,B,B,C,D. Write lasts 5 cycles; `ufp_ready=0` until return to `IDLE`.
- Back-to-back reads → second read accepted in the `ufp_rvalid` cycle of the first. Both lines correct.
- Request with `bmem_ready=0` → `ufp_ready=0`, no `bmem_read`. Accepted on the first cycle `bmem_ready=1`.
- Assert `rst` after 2 read beats, then release and deliver 2 stray beats → no `ufp_rvalid`. `ufp_rdata=0`, FSM in `IDLE`, next read completes normally.
- Unaligned `ufp_addr` 0x0000_105C → `bmem_addr=0x0000_1040`.
